// File: rtl/lifi_tx_pkg.sv
// Shared types, sizes and helpers for the LiFi transmit wrapper.
// Walsh row masks and the serial CRC-4 step live here so that checkers can reuse them.
package lifi_tx_pkg;

    localparam int unsigned PAM_LEVEL_LOG = 2;
    localparam int unsigned HADAMARD      = 4;
    localparam int unsigned BIT_NUM       = 4;
    localparam int unsigned CRC_BITS      = 4;

    function automatic int unsigned data_bits_f(input int unsigned pam_log, input int unsigned hadamard);
        return pam_log * (hadamard - 1);
    endfunction

    function automatic int unsigned frame_bits_f(input int unsigned hadamard, input int unsigned bit_num);
        return hadamard * bit_num + CRC_BITS;
    endfunction

    localparam int unsigned DATA_BITS    = data_bits_f(PAM_LEVEL_LOG, HADAMARD);
    localparam int unsigned PAYLOAD_BITS = HADAMARD * BIT_NUM;
    localparam int unsigned FRAME_BITS   = frame_bits_f(HADAMARD, BIT_NUM);
    localparam int unsigned ROW_W        = $clog2(HADAMARD);
    localparam int unsigned BIT_CNT_W    = $clog2(PAYLOAD_BITS);

    localparam logic [CRC_BITS-1:0] CRC4_POLY = 4'b0011;
    localparam logic [CRC_BITS-1:0] CRC4_INIT = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SPREAD = 2'd1,
        ST_CRC    = 2'd2,
        ST_HOLD   = 2'd3
    } tx_state_e;

    // Sylvester row k has +1 at column j when k&j has even parity.
    function automatic logic walsh_bit(input logic [ROW_W-1:0] k, input logic [ROW_W-1:0] j);
        return ~^(k & j);
    endfunction

    // One MSB-first step of x^4+x+1 division.
    function automatic logic [CRC_BITS-1:0] crc4_step(input logic [CRC_BITS-1:0] crc,
                                                      input logic                bit_in);
        logic fb;
        fb = crc[CRC_BITS-1] ^ bit_in;
        return {crc[CRC_BITS-2:0], 1'b0} ^ (fb ? CRC4_POLY : {CRC_BITS{1'b0}});
    endfunction

endpackage

// File: rtl/crc4_serial_encoder.sv
// Bit-serial CRC-4 (x^4+x+1), MSB first, zero init, no reflection or final XOR.
module crc4_serial_encoder
    import lifi_tx_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                clear,
    input  logic                bit_in,
    input  logic                bit_valid,
    output logic [CRC_BITS-1:0] crc
);

    logic [CRC_BITS-1:0] crc_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crc_q <= CRC4_INIT;
        end else if (clear) begin
            crc_q <= CRC4_INIT;
        end else if (bit_valid) begin
            crc_q <= crc4_step(crc_q, bit_in);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/wrapper_transmitter.sv
// Transmit wrapper: PAM split, Walsh spreading onto rows 1..H-1, then serial CRC-4 append.
// Produces the exact frame word the receive wrapper consumes; one frame in flight at a time.
module wrapper_transmitter
    import lifi_tx_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_BITS-1:0]  in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FRAME_BITS-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    tx_state_e                               state_q, state_d;
    logic [DATA_BITS-1:0]                    data_q, data_d;
    logic [HADAMARD-1:0][BIT_NUM-1:0]        chips_q, chips_d;
    logic [ROW_W-1:0]                        row_q, row_d;
    logic [BIT_CNT_W-1:0]                    bit_q, bit_d;
    logic [FRAME_BITS-1:0]                   out_data_q, out_data_d;
    logic                                    out_valid_q, out_valid_d;
    logic                                    in_ready_q, in_ready_d;

    logic [PAM_LEVEL_LOG-1:0]                sym_c;
    logic [PAYLOAD_BITS-1:0]                 payload_c;
    logic                                    crc_bit_c;
    logic                                    crc_clear_c;
    logic                                    crc_valid_c;
    logic [CRC_BITS-1:0]                     crc_c;

    // Current row's symbol and the chip vector packed chip0-first.
    always_comb begin
        sym_c     = '0;
        payload_c = '0;
        for (int k = 1; k < int'(HADAMARD); k++) begin
            if (row_q == ROW_W'(k)) begin
                sym_c = data_q[(int'(HADAMARD) - 1 - k) * int'(PAM_LEVEL_LOG) +: PAM_LEVEL_LOG];
            end
        end
        for (int j = 0; j < int'(HADAMARD); j++) begin
            payload_c[(int'(HADAMARD) - 1 - j) * int'(BIT_NUM) +: BIT_NUM] = chips_q[j];
        end
    end

    assign crc_bit_c = payload_c[BIT_CNT_W'(PAYLOAD_BITS - 1) - bit_q];

    crc4_serial_encoder u_crc (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (crc_clear_c),
        .bit_in    (crc_bit_c),
        .bit_valid (crc_valid_c),
        .crc       (crc_c)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            chips_q     <= '0;
            row_q       <= '0;
            bit_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            chips_q     <= chips_d;
            row_q       <= row_d;
            bit_q       <= bit_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        chips_d     = chips_q;
        row_d       = row_q;
        bit_d       = bit_q;
        out_data_d  = out_data_q;
        crc_clear_c = 1'b0;
        crc_valid_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    data_d      = in_data;
                    chips_d     = '0;
                    row_d       = ROW_W'(1);
                    bit_d       = '0;
                    crc_clear_c = 1'b1;
                    state_d     = ST_SPREAD;
                end
            end
            ST_SPREAD: begin
                for (int j = 0; j < int'(HADAMARD); j++) begin
                    if (walsh_bit(row_q, ROW_W'(j))) begin
                        chips_d[j] = chips_q[j] + BIT_NUM'(sym_c);
                    end
                end
                row_d = row_q + ROW_W'(1);
                if (row_q == ROW_W'(HADAMARD - 1)) begin
                    bit_d   = '0;
                    state_d = ST_CRC;
                end
            end
            ST_CRC: begin
                crc_valid_c = 1'b1;
                bit_d       = bit_q + BIT_CNT_W'(1);
                // Last bit: fold it in here so the frame loads on the same edge.
                if (bit_q == BIT_CNT_W'(PAYLOAD_BITS - 1)) begin
                    out_data_d = {payload_c, crc4_step(crc_c, crc_bit_c)};
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_HOLD);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_wrapper_transmitter.sv
// Self-checking bench for wrapper_transmitter: directed table, handshake corner cases,
// and a full 64-word sweep against a polynomial-division / Walsh-correlation reference.
module tb_wrapper_transmitter;
    import lifi_tx_pkg::*;

    logic                  clk;
    logic                  resetn;
    logic [DATA_BITS-1:0]  in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [FRAME_BITS-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    int tests;
    int fails;

    wrapper_transmitter dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  din;
        logic [19:0] exp_frame;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Remainder of a 20-bit polynomial divided by x^4+x+1 (long division).
    function automatic logic [3:0] poly_rem(input logic [19:0] v);
        logic [19:0] r;
        r = v;
        for (int i = 19; i >= 4; i--) begin
            if (r[i]) r = r ^ (20'(5'b10011) << (i - 4));
        end
        return r[3:0];
    endfunction

    function automatic logic [19:0] model_frame(input logic [5:0] d);
        int          s [4];
        int          chip [4];
        logic [15:0] pay;
        s[0] = 0;
        for (int k = 1; k < 4; k++) s[k] = int'((d >> (2 * (3 - k))) & 6'd3);
        for (int j = 0; j < 4; j++) begin
            chip[j] = 0;
            for (int k = 1; k < 4; k++)
                if (($countones(k & j) % 2) == 0) chip[j] += s[k];
        end
        pay = {4'(chip[0]), 4'(chip[1]), 4'(chip[2]), 4'(chip[3])};
        return {pay, poly_rem({pay, 4'b0000})};
    endfunction

    // Receiver view: correlate chips with bipolar Walsh rows, scale by 2/H.
    function automatic logic [5:0] decode(input logic [19:0] f);
        int         c [4];
        int         acc;
        logic [5:0] d;
        d = '0;
        for (int j = 0; j < 4; j++) c[j] = int'((f >> (16 - 4 * j)) & 20'hF);
        for (int k = 1; k < 4; k++) begin
            acc = 0;
            for (int j = 0; j < 4; j++)
                acc += (($countones(k & j) % 2) == 0) ? c[j] : -c[j];
            d = d | (6'(acc / 2) << (2 * (3 - k)));
        end
        return d;
    endfunction

    // Send one word from IDLE, wait for out_valid, hold for 'hold' cycles, then handshake.
    task automatic run_word(input logic [5:0] d, input int hold,
                            output logic [19:0] frame, output int lat);
        out_ready = 1'b0;
        in_data   = d;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        frame = out_data;
        for (int i = 0; i < hold; i++) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    vec_t        vecs [3];
    logic [19:0] frame;
    logic [19:0] exp_f;
    logic [19:0] frames [2];
    int          acc_cyc [2];
    int          lat;
    int          nacc;
    int          nfr;
    int          cyc;
    logic        will_acc;
    logic        seen_valid;
    logic [5:0]  perm [64];
    logic [5:0]  tmp;
    int          r;

    initial begin
        tests     = 0;
        fails     = 0;
        resetn    = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{din: 6'b01_10_11, exp_frame: 20'h62131};
        vecs[1] = '{din: 6'b00_00_00, exp_frame: 20'h00000};
        vecs[2] = '{din: 6'b11_11_11, exp_frame: 20'h93339};

        step();
        step();
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        resetn = 1'b1;
        step();

        // Directed table with latency check.
        for (int i = 0; i < 3; i++) begin
            run_word(vecs[i].din, 0, frame, lat);
            check("vec_frame", 32'(frame), 32'(vecs[i].exp_frame));
            check("vec_latency", 32'(lat), 32'd19);
            check("vec_in_ready_after", 32'(in_ready), 32'd1);
        end

        // Backpressure: hold 10 cycles, pulse in_valid while held.
        exp_f    = model_frame(6'h27);
        in_data  = 6'h27;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            step();
            cyc++;
        end
        check("bp_first_frame", 32'(out_data), 32'(exp_f));
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                in_data  = 6'h3C;
                in_valid = 1'b1;
            end
            step();
            in_valid = 1'b0;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'(exp_f));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        seen_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (out_valid) seen_valid = 1'b1;
        end
        check("bp_pulse_ignored", 32'(seen_valid), 32'd0);
        check("bp_data_retained", 32'(out_data), 32'(exp_f));

        // Back-to-back with in_valid held high.
        in_data   = 6'h2D;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        nacc = 0;
        nfr  = 0;
        cyc  = 0;
        frames[0]  = '0;
        frames[1]  = '0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        while (nfr < 2 && cyc < 120) begin
            will_acc = in_ready && in_valid;
            step();
            cyc++;
            if (will_acc && nacc < 2) begin
                acc_cyc[nacc] = cyc;
                nacc++;
                if (nacc == 1) in_data = 6'h12;
                else           in_valid = 1'b0;
            end
            if (out_valid) begin
                frames[nfr] = out_data;
                nfr++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_frames", 32'(nfr), 32'd2);
        check("b2b_frame0", 32'(frames[0]), 32'(model_frame(6'h2D)));
        check("b2b_frame1", 32'(frames[1]), 32'(model_frame(6'h12)));
        check("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd21);
        step();

        // Reset mid-CRC discards the partial frame.
        in_data  = 6'h15;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        #2;
        resetn = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_data", 32'(out_data), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        step();
        step();
        resetn = 1'b1;
        step();
        run_word(6'h2A, 1, frame, lat);
        check("post_abort_frame", 32'(frame), 32'(model_frame(6'h2A)));
        check("post_abort_latency", 32'(lat), 32'd19);

        // Sweep all 64 words in shuffled order with random backpressure.
        for (int i = 0; i < 64; i++) perm[i] = 6'(i);
        for (int i = 63; i > 0; i--) begin
            r       = int'($urandom_range(0, i));
            tmp     = perm[i];
            perm[i] = perm[r];
            perm[r] = tmp;
        end
        for (int i = 0; i < 64; i++) begin
            run_word(perm[i], int'($urandom_range(0, 3)), frame, lat);
            check("sweep_frame", 32'(frame), 32'(model_frame(perm[i])));
            check("sweep_crc_rem", 32'(poly_rem(frame)), 32'd0);
            check("sweep_decode", 32'(decode(frame)), 32'(perm[i]));
            check("sweep_latency", 32'(lat), 32'd19);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
